// File: rtl/geo_writer_pkg.sv
// rtl/geo_writer_pkg.sv - shared definitions for the geometric co-processor instruction writer
//
// Purpose: instruction field layout, reserved slot number, writer FSM
// encoding and the command-to-instruction pack function.
// Ports: none (package).
// Build option: GEO_WRITER_SHADOW_EN (used by geo_instruction_writer only).

package geo_writer_pkg;

   localparam int INSTR_W   = 32;
   localparam int SLOT_W    = 4;
   localparam int ENTRY_W   = SLOT_W + INSTR_W;

   localparam int X_LSB     = 0;
   localparam int X_W       = 9;
   localparam int Y_LSB     = 9;
   localparam int Y_W       = 9;
   localparam int MULT_LSB  = 18;
   localparam int MULT_W    = 4;
   localparam int COLOR_LSB = 22;
   localparam int COLOR_W   = 9;
   localparam int FORM_BIT  = 31;

   localparam logic [SLOT_W-1:0] RESERVED_SLOT = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_ACK = 2'd2
   } wr_state_e;

   function automatic logic [INSTR_W-1:0] pack_instr(
      input logic [X_W-1:0]     x,
      input logic [Y_W-1:0]     y,
      input logic [MULT_W-1:0]  mult,
      input logic [COLOR_W-1:0] color,
      input logic               form
   );
      logic [INSTR_W-1:0] w;
      w                         = '0;
      w[X_LSB     +: X_W]       = x;
      w[Y_LSB     +: Y_W]       = y;
      w[MULT_LSB  +: MULT_W]    = mult;
      w[COLOR_LSB +: COLOR_W]   = color;
      w[FORM_BIT]               = form;
      return w;
   endfunction

endpackage

// File: rtl/geo_cmd_fifo.sv
// rtl/geo_cmd_fifo.sv - synchronous command FIFO for the instruction writer
//
// Purpose: DEPTH-entry first-word-fall-through FIFO (head visible on
// head_data whenever empty is low).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write request (ignored when full)
//   pop              drop the head entry (ignored when empty)
//   head_data        current head entry
//   full, empty      registered-state occupancy flags

module geo_cmd_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/geo_instruction_writer.sv
// rtl/geo_instruction_writer.sv - instruction-memory write port producer for the geometric co-processor
//
// Purpose: accepts polygon commands, queues them, packs them into 32-bit
// instructions and issues one-cycle writes outside screen printing, waiting
// for the co-processor acknowledge (with timeout) between writes.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   printtingScreen                 blocks new writes while high
//   cmd_valid/cmd_ready, cmd_*      command handshake and fields
//   enable_written, in_address,     write strobe, address and word
//   instruction
//   w_memory                        write acknowledge
//   busy                            queue non-empty or write in progress
//   err_slot, err_timeout           one-cycle error pulses
// Build option: GEO_WRITER_SHADOW_EN enables per-slot skipping of writes
// identical to the last acknowledged instruction.

module geo_instruction_writer
   import geo_writer_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        printtingScreen,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_slot,
   input  logic [8:0]  cmd_x,
   input  logic [8:0]  cmd_y,
   input  logic [3:0]  cmd_mult,
   input  logic [8:0]  cmd_color,
   input  logic        cmd_form,
   output logic        enable_written,
   output logic [3:0]  in_address,
   output logic [31:0] instruction,
   input  logic        w_memory,
   output logic        busy,
   output logic        err_slot,
   output logic        err_timeout
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   wr_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic               enable_written_q, enable_written_d;
   logic [SLOT_W-1:0]  in_address_q, in_address_d;
   logic [INSTR_W-1:0] instruction_q, instruction_d;
   logic               err_slot_q, err_slot_d;
   logic               err_timeout_q, err_timeout_d;

   logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [ENTRY_W-1:0] fifo_head;
   logic [SLOT_W-1:0]  head_slot;
   logic [INSTR_W-1:0] head_word;
   logic               accept;
   logic               shadow_hit;

   assign cmd_ready = reset && !fifo_full;
   assign accept    = cmd_valid && cmd_ready;
   // Reserved-slot commands complete the handshake but never enter the queue.
   assign fifo_push = accept && (cmd_slot != RESERVED_SLOT);
   assign head_slot = fifo_head[INSTR_W +: SLOT_W];
   assign head_word = fifo_head[INSTR_W-1:0];

   geo_cmd_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push      (fifo_push),
      .push_data ({cmd_slot, pack_instr(cmd_x, cmd_y, cmd_mult, cmd_color, cmd_form)}),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef GEO_WRITER_SHADOW_EN
   localparam int SHADOW_N = 15;
   logic [INSTR_W-1:0]  shadow_q [SHADOW_N];
   logic [SHADOW_N-1:0] shadow_vld_q, shadow_vld_d;
   logic                shadow_we;

   assign shadow_hit = shadow_vld_q[head_slot] && (shadow_q[head_slot] == head_word);

   always_ff @(posedge clk) begin
      if (shadow_we) shadow_q[in_address_q] <= instruction_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) shadow_vld_q <= '0;
      else        shadow_vld_q <= shadow_vld_d;
   end
`else
   assign shadow_hit = 1'b0;
`endif

   assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      enable_written_d = 1'b0;
      in_address_d     = in_address_q;
      instruction_d    = instruction_q;
      err_timeout_d    = 1'b0;
      err_slot_d       = accept && (cmd_slot == RESERVED_SLOT);
      fifo_pop         = 1'b0;
`ifdef GEO_WRITER_SHADOW_EN
      shadow_vld_d     = shadow_vld_q;
      shadow_we        = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               // A redundant write is dropped even while the screen prints.
               if (shadow_hit) begin
                  fifo_pop = 1'b1;
               end else if (!printtingScreen) begin
                  fifo_pop         = 1'b1;
                  in_address_d     = head_slot;
                  instruction_d    = head_word;
                  enable_written_d = 1'b1;
                  state_d          = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (w_memory) begin
               state_d = ST_IDLE;
`ifdef GEO_WRITER_SHADOW_EN
               shadow_we                  = 1'b1;
               shadow_vld_d[in_address_q] = 1'b1;
`endif
            end else if (cnt_inc == CNT_W'(ACK_TIMEOUT)) begin
               // The counter reaches ACK_TIMEOUT on this cycle: give up.
               err_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= ST_IDLE;
         cnt_q            <= '0;
         enable_written_q <= 1'b0;
         in_address_q     <= '0;
         instruction_q    <= '0;
         err_slot_q       <= 1'b0;
         err_timeout_q    <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         enable_written_q <= enable_written_d;
         in_address_q     <= in_address_d;
         instruction_q    <= instruction_d;
         err_slot_q       <= err_slot_d;
         err_timeout_q    <= err_timeout_d;
      end
   end

   assign enable_written = enable_written_q;
   assign in_address     = in_address_q;
   assign instruction    = instruction_q;
   assign err_slot       = err_slot_q;
   assign err_timeout    = err_timeout_q;
   assign busy           = !fifo_empty || (state_q != ST_IDLE);

endmodule
